serial_mag_comparator: RTL and testbench
========================================

SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK, and NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a comparison; sampled only in IDLE
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned
- a  input  WIDTH  operand A, captured when start is accepted
- b  input  WIDTH  operand B, captured when start is accepted
- busy  output  1  high while in RUN
- done  output  1  single-cycle result-valid pulse
- aeb  output  1  A equals B
- agb  output  1  A greater than B
- alb  output  1  A less than B
REQ-004 SHALL take its clock from clk and a synchronous, active-high reset from rst; no other clock or reset exists.

Function
REQ-005 SHALL implement the states IDLE, RUN and DONE.
REQ-006 In IDLE with start=1 at a clock edge, the block SHALL capture a, b and signed_mode, clear aeb/agb/alb to 0, set the chunk index to NCHUNK-1, and enter RUN.
REQ-007 In RUN, the block SHALL compare one CHUNK-bit slice per cycle, most significant chunk first.
REQ-008 When the slices differ, the block SHALL set agb or alb accordingly and enter DONE (early termination).
REQ-009 When the slices are equal and the index is 0, the block SHALL set aeb and enter DONE; when the slices are equal and the index is nonzero, it SHALL decrement the index and stay in RUN.
REQ-010 When the captured signed_mode is 1, the most significant chunk SHALL be compared as signed and all lower chunks as unsigned; when it is 0, all chunks SHALL be compared as unsigned.
REQ-011 DONE SHALL last exactly one cycle, with done=1 in that cycle only, and SHALL then return to IDLE.
REQ-012 Latency: done SHALL be high in the cycle beginning N rising edges after the edge that accepted start, where N is the number of chunks examined (1..NCHUNK).
REQ-013 After done, exactly one of aeb/agb/alb SHALL be 1, and the flags SHALL hold their values until the next start is accepted.
REQ-014 start SHALL be ignored in RUN and DONE; changes on a, b or signed_mode after capture SHALL NOT affect the result.
REQ-015 With start held high continuously, the next comparison SHALL be accepted on the edge that ends the IDLE cycle following DONE (back-to-back throughput = N+2 cycles).
REQ-016 With CHUNK=WIDTH, the block SHALL complete in a single RUN cycle (N=1).
REQ-017 busy SHALL be 1 exactly when the state is RUN.

Reset
REQ-018 rst=1 at a clock edge SHALL force IDLE and drive busy, done, aeb, agb and alb to 0, regardless of state, including mid-RUN.
REQ-019 rst SHALL take priority over start at the same edge.
REQ-020 After rst is released, the first start SHALL behave per REQ-006 with no residue from the aborted operation.

Structure
REQ-021 The state enumeration (IDLE/RUN/DONE) SHALL be defined in a shared package, serial_cmp_pkg.
REQ-022 Any result-code constants SHALL also be defined in serial_cmp_pkg.
REQ-023 The per-slice compare SHALL be a combinational sub-module, chunk_cmp, parameterised by CHUNK, with a signed-enable input, operand inputs x and y, and outputs eq, gt and lt.
REQ-024 The top-level module SHALL hold the FSM, the chunk index counter, the operand registers and the result registers.

Verification (WIDTH=16, CHUNK=4)
REQ-025 Bench SHALL apply a=0x1234, b=0x1234, unsigned, start -> done 4 edges after accept, aeb=1, agb=0, alb=0.
REQ-026 Bench SHALL apply a=0x8000, b=0x7FFF -> unsigned: agb=1 after 1 edge; signed: alb=1 after 1 edge.
REQ-027 Bench SHALL apply a=0x12A0, b=0x12B0 -> alb=1 after 3 edges; change a during RUN -> result unchanged.
REQ-028 Bench SHALL pulse start during RUN (ignored), then assert rst mid-RUN -> busy, done and flags all 0 and state IDLE next cycle; a new start then completes correctly.
REQ-029 Bench SHALL hold start high over 3 operand pairs -> three done pulses, each separated per REQ-015, with flags correct for each pair.
REQ-030 Bench SHALL run with CHUNK=16 and a=0xFFFF, b=0x0001 signed -> alb=1, done 1 edge after accept.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared FSM state and result-code definitions for the serial comparator
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One-hot result codes laid out as {agb, aeb, alb}
    typedef enum logic [2:0] {
        RES_NONE = 3'b000,
        RES_LT   = 3'b001,
        RES_EQ   = 3'b010,
        RES_GT   = 3'b100
    } res_e;

    // Chunk index width; a single-chunk configuration still needs a 1-bit index
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunk_cmp.sv
// rtl/chunk_cmp.sv - combinational compare of one CHUNK-bit slice, optionally signed
module chunk_cmp #(
    parameter int CHUNK = 4
) (
    input  logic             signed_en,
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam logic [CHUNK-1:0] MSB = CHUNK'(1) << (CHUNK - 1);

    logic [CHUNK-1:0] flip;
    logic [CHUNK-1:0] xb;
    logic [CHUNK-1:0] yb;

    // Inverting the sign bit maps two's-complement order onto unsigned order
    always_comb begin
        flip = signed_en ? MSB : '0;
        xb   = x ^ flip;
        yb   = y ^ flip;
        eq   = (x == y);
        gt   = (xb > yb);
        lt   = (xb < yb);
    end

endmodule

// File: rtl/serial_mag_comparator.sv
// rtl/serial_mag_comparator.sv - multi-cycle magnitude comparator, MS chunk first with early exit
module serial_mag_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             aeb,
    output logic             agb,
    output logic             alb
);

    localparam int            NCHUNK = WIDTH / CHUNK;
    localparam int            IW     = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST   = IW'(NCHUNK - 1);

    state_e           state;
    state_e           next_state;
    logic             load;
    logic             finish;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sm_q;
    logic [IW-1:0]    idx;
    res_e             res;
    logic [CHUNK-1:0] xs;
    logic [CHUNK-1:0] ys;
    logic             c_eq;
    logic             c_gt;
    logic             c_lt;

    // Select the current slice; only the top slice carries the sign
    always_comb begin
        xs = a_q[int'(idx)*CHUNK +: CHUNK];
        ys = b_q[int'(idx)*CHUNK +: CHUNK];
    end

    chunk_cmp #(
        .CHUNK(CHUNK)
    ) u_chunk_cmp (
        .signed_en(sm_q & (idx == LAST)),
        .x        (xs),
        .y        (ys),
        .eq       (c_eq),
        .gt       (c_gt),
        .lt       (c_lt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a RUN cycle finishes on the first differing slice or the last slice
    always_comb begin
        next_state = state;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!c_eq || idx == '0) begin
                    finish     = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, chunk index walk and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            sm_q <= 1'b0;
            idx  <= '0;
            res  <= RES_NONE;
        end else if (load) begin
            a_q  <= a;
            b_q  <= b;
            sm_q <= signed_mode;
            idx  <= LAST;
            res  <= RES_NONE;
        end else if (finish) begin
            res <= c_gt ? RES_GT : (c_lt ? RES_LT : RES_EQ);
        end else if (state == RUN) begin
            idx <= idx - 1'b1;
        end
    end

    // Status and result outputs
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
        agb  = (res == RES_GT);
        aeb  = (res == RES_EQ);
        alb  = (res == RES_LT);
    end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb/tb_serial_mag_comparator.sv - scoreboard bench for serial_mag_comparator (CHUNK=4 and CHUNK=16)
module tb_serial_mag_comparator;

    typedef struct {
        logic [2:0] res;
        int         cyc;
        string      tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic        start_a = 1'b0;
    logic        sm_a = 1'b0;
    logic [15:0] opa_a = '0;
    logic [15:0] opb_a = '0;
    logic        busy_a, done_a, aeb_a, agb_a, alb_a;

    logic        start_b = 1'b0;
    logic        sm_b = 1'b0;
    logic [15:0] opa_b = '0;
    logic [15:0] opb_b = '0;
    logic        busy_b, done_b, aeb_b, agb_b, alb_b;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [2:0]  last_a = 3'b000;

    serial_mag_comparator #(.WIDTH(16), .CHUNK(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .signed_mode(sm_a),
        .a(opa_a), .b(opb_a), .busy(busy_a), .done(done_a),
        .aeb(aeb_a), .agb(agb_a), .alb(alb_a)
    );

    serial_mag_comparator #(.WIDTH(16), .CHUNK(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .signed_mode(sm_b),
        .a(opa_b), .b(opb_b), .busy(busy_b), .done(done_b),
        .aeb(aeb_b), .agb(agb_b), .alb(alb_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word compare; chunks examined = down to the highest differing chunk
    function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic sm,
                                  input int ch, output logic [2:0] r, output int n);
        logic [15:0] d;
        int          p;
        d = x ^ y;
        p = -1;
        for (int i = 0; i < 16; i++) if (d[i]) p = i;
        if (p < 0) n = 16 / ch;
        else       n = (15 - p) / ch + 1;
        if (x == y) r = 3'b010;
        else if (sm ? ($signed(x) > $signed(y)) : (x > y)) r = 3'b100;
        else r = 3'b001;
    endfunction

    // Called just after a rising edge with the target DUT idle; returns just after the accept edge
    task automatic issue(input bit d, input logic [15:0] x, input logic [15:0] y,
                         input logic sm, input string tag);
        exp_t       e;
        int         n;
        logic [2:0] r;
        model(x, y, sm, d ? 16 : 4, r, n);
        e.res = r;
        e.cyc = cyc + 1 + n;
        e.tag = tag;
        if (d) begin
            opa_b = x; opb_b = y; sm_b = sm; start_b = 1'b1;
            qb.push_back(e);
        end else begin
            opa_a = x; opb_a = y; sm_a = sm; start_a = 1'b1;
            qa.push_back(e);
        end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic drain(input string tag);
        int i;
        i = 0;
        while ((qa.size() != 0 || qb.size() != 0) && i < 40) begin
            @(posedge clk); #1;
            i++;
        end
        chk({tag, " drain"}, qa.size() + qb.size(), 0);
        qa.delete();
        qb.delete();
        @(posedge clk); #1;
    endtask

    // Scoreboard: pop on each done pulse and compare flags and arrival cycle
    always @(negedge clk) begin
        exp_t e;
        if (done_a) begin
            if (qa.size() == 0) chk("A unexpected done", 1, 0);
            else begin
                e = qa.pop_front();
                chk({e.tag, " flags"}, {agb_a, aeb_a, alb_a}, e.res);
                chk({e.tag, " latency"}, cyc, e.cyc);
                chk({e.tag, " busy@done"}, busy_a, 0);
                last_a = e.res;
            end
        end
        if (done_b) begin
            if (qb.size() == 0) chk("B unexpected done", 1, 0);
            else begin
                e = qb.pop_front();
                chk({e.tag, " flags"}, {agb_b, aeb_b, alb_b}, e.res);
                chk({e.tag, " latency"}, cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pa[3];
        logic [15:0] pb[3];
        logic        ps[3];
        int          acc;
        int          n;
        logic [2:0]  r;
        exp_t        e;

        repeat (3) @(posedge clk);
        #1;
        chk("reset A busy/done", {busy_a, done_a}, 2'b00);
        chk("reset A flags", {agb_a, aeb_a, alb_a}, 3'b000);
        chk("reset B busy/done", {busy_b, done_b}, 2'b00);
        chk("reset B flags", {agb_b, aeb_b, alb_b}, 3'b000);
        rst = 1'b0;
        @(posedge clk); #1;

        issue(0, 16'h1234, 16'h1234, 1'b0, "eq1234");
        chk("eq1234 busy", busy_a, 1);
        drain("eq1234");
        repeat (2) @(posedge clk);
        #1;
        chk("eq1234 hold", {agb_a, aeb_a, alb_a}, last_a);

        issue(0, 16'h8000, 16'h7FFF, 1'b0, "u8000");
        drain("u8000");
        issue(0, 16'h8000, 16'h7FFF, 1'b1, "s8000");
        drain("s8000");

        issue(0, 16'h12A0, 16'h12B0, 1'b0, "chg12A0");
        opa_a = 16'hFFFF;
        opb_a = 16'h0000;
        sm_a  = 1'b1;
        drain("chg12A0");

        // Ignored start in RUN, then reset mid-RUN
        issue(0, 16'h1234, 16'h1234, 1'b0, "abort");
        start_a = 1'b1;
        opa_a = 16'h0000;
        opb_a = 16'hFFFF;
        @(posedge clk); #1;
        chk("abort still busy", busy_a, 1);
        start_a = 1'b0;
        rst = 1'b1;
        qa.delete();
        @(posedge clk); #1;
        chk("rst mid busy/done", {busy_a, done_a}, 2'b00);
        chk("rst mid flags", {agb_a, aeb_a, alb_a}, 3'b000);
        start_a = 1'b1;
        @(posedge clk); #1;
        chk("rst over start busy", busy_a, 0);
        start_a = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        issue(0, 16'h00F0, 16'h00E0, 1'b0, "post_rst");
        drain("post_rst");

        // Back-to-back with start held high
        pa[0] = 16'h1234; pb[0] = 16'h1234; ps[0] = 1'b0;
        pa[1] = 16'hF000; pb[1] = 16'h1000; ps[1] = 1'b1;
        pa[2] = 16'h1200; pb[2] = 16'h1300; ps[2] = 1'b0;
        acc = cyc + 1;
        start_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            opa_a = pa[i]; opb_a = pb[i]; sm_a = ps[i];
            model(pa[i], pb[i], ps[i], 4, r, n);
            e.res = r;
            e.cyc = acc + n;
            e.tag = $sformatf("b2b%0d", i);
            qa.push_back(e);
            while (cyc < acc) begin
                @(posedge clk); #1;
            end
            acc = acc + n + 2;
        end
        start_a = 1'b0;
        drain("b2b");

        issue(1, 16'hFFFF, 16'h0001, 1'b1, "c16_signed");
        drain("c16_signed");
        issue(1, 16'hFFFF, 16'h0001, 1'b0, "c16_unsigned");
        drain("c16_unsigned");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
